// File: rtl/clock_pkg.sv
// Shared constants and helpers for the clock-enable generator.
`timescale 1ns/1ps
package clock_pkg;

    localparam int CLK_DIVISOR_DEFAULT = 8;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_mod_counter.sv
// Modulo-N counter with enable; flags terminal count (N-1) and half count (N/2-1).
// Synchronous active-high reset; flags are combinational decodes of the count register.
`timescale 1ns/1ps
module clk_mod_counter
    import clock_pkg::*;
#(
    parameter int N  = CLK_DIVISOR_DEFAULT,
    parameter int CW = cnt_width(N)
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc,
    output logic hc
);

    localparam logic [CW-1:0] TC_VAL = CW'(N - 1);
    localparam logic [CW-1:0] HC_VAL = CW'(N / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);
    assign hc = (cnt_q == HC_VAL);

endmodule

// File: rtl/clock_enable.sv
// Slow-rate qualifiers (clken, clken2, slowclk) from sysclk; all outputs registered, one cycle after the count decode.
// Optional CLOCKEN_HALT_EN adds a halt input that freezes the count and suppresses pulses.
`timescale 1ns/1ps
module clock_enable
    import clock_pkg::*;
#(
    parameter int DIVISOR = CLK_DIVISOR_DEFAULT
)
(
    input  logic sysclk,
    input  logic reset,
`ifdef CLOCKEN_HALT_EN
    input  logic halt,
`endif
    output logic clken,
    output logic clken2,
    output logic slowclk
);

    generate
        if (DIVISOR < 2 || (DIVISOR % 2) != 0) begin : g_bad_divisor
            $error("clock_enable: DIVISOR must be even and at least 2");
        end
    endgenerate

    logic run;
    logic tc;
    logic hc;

`ifdef CLOCKEN_HALT_EN
    assign run = ~halt;
`else
    assign run = 1'b1;
`endif

    clk_mod_counter #(.N(DIVISOR)) u_cnt (
        .clk (sysclk),
        .rst (reset),
        .en  (run),
        .tc  (tc),
        .hc  (hc)
    );

    logic clken_q,   clken_d;
    logic clken2_q,  clken2_d;
    logic slowclk_q, slowclk_d;

    // slowclk edges coincide with the pulse edges, so its duty is exactly half.
    always_comb begin
        clken_d   = run & tc;
        clken2_d  = run & hc;
        slowclk_d = slowclk_q;
        if (run && hc) begin
            slowclk_d = 1'b1;
        end else if (run && tc) begin
            slowclk_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            clken_q   <= 1'b0;
            clken2_q  <= 1'b0;
            slowclk_q <= 1'b0;
        end else begin
            clken_q   <= clken_d;
            clken2_q  <= clken2_d;
            slowclk_q <= slowclk_d;
        end
    end

    assign clken   = clken_q;
    assign clken2  = clken2_q;
    assign slowclk = slowclk_q;

endmodule

// File: tb/tb_clock_enable.sv
// Bench for clock_enable at DIVISOR 8, 2 and 16; edge-count reference model plus directed sequences.
`timescale 1ns/1ps
module tb_clock_enable;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic halt   = 1'b0;

    logic clken8, clken2_8, slow8;
    logic clken2x, clken2_2, slow2;
    logic clken16, clken2_16, slow16;

    always #1 sysclk = ~sysclk;

    clock_enable #(.DIVISOR(8)) dut8 (
        .sysclk(sysclk), .reset(reset),
`ifdef CLOCKEN_HALT_EN
        .halt(halt),
`endif
        .clken(clken8), .clken2(clken2_8), .slowclk(slow8)
    );

    clock_enable #(.DIVISOR(2)) dut2 (
        .sysclk(sysclk), .reset(reset),
`ifdef CLOCKEN_HALT_EN
        .halt(halt),
`endif
        .clken(clken2x), .clken2(clken2_2), .slowclk(slow2)
    );

    clock_enable #(.DIVISOR(16)) dut16 (
        .sysclk(sysclk), .reset(reset),
`ifdef CLOCKEN_HALT_EN
        .halt(halt),
`endif
        .clken(clken16), .clken2(clken2_16), .slowclk(slow16)
    );

    logic [2:0] o_ck, o_c2, o_sl;
    assign o_ck = {clken16, clken2x, clken8};
    assign o_c2 = {clken2_16, clken2_2, clken2_8};
    assign o_sl = {slow16, slow2, slow8};

    int dv [3] = '{8, 2, 16};
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: position within the period derived from edges since reset release.
    typedef struct packed {
        logic [2:0] ck;
        logic [2:0] c2;
        logic [2:0] sl;
    } exp_t;

    exp_t sb_q [$];
    int   k_m [3] = '{0, 0, 0};
    logic [2:0] slow_m = '0;

    always @(posedge sysclk) begin
        exp_t e;
        int   m;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                k_m[i]    = 0;
                slow_m[i] = 1'b0;
            end else if (!halt) begin
                k_m[i]    = k_m[i] + 1;
                m         = k_m[i] % dv[i];
                e.ck[i]   = (m == 0);
                e.c2[i]   = (m == dv[i] / 2);
                slow_m[i] = (m >= dv[i] / 2);
            end
            e.sl[i] = slow_m[i];
        end
        sb_q.push_back(e);
    end

    realtime prev_rise [3] = '{-1.0, -1.0, -1.0};
    realtime per_last  [3] = '{0.0, 0.0, 0.0};

    always @(negedge sysclk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("sb_clken_d%0d", dv[i]),   32'(o_ck[i]), 32'(e.ck[i]));
                check($sformatf("sb_clken2_d%0d", dv[i]),  32'(o_c2[i]), 32'(e.c2[i]));
                check($sformatf("sb_slowclk_d%0d", dv[i]), 32'(o_sl[i]), 32'(e.sl[i]));
                check($sformatf("overlap_d%0d", dv[i]),    32'(o_ck[i] & o_c2[i]), 32'd0);
                if (o_ck[i] === 1'b1) begin
                    if (prev_rise[i] >= 0.0) per_last[i] = $realtime - prev_rise[i];
                    prev_rise[i] = $realtime;
                end
            end
        end
    end

    realtime t_c2 = -1.0, t_ck = -1.0, t_sr = -1.0, t_sf = -1.0;
    always @(posedge clken2_8) if (t_c2 < 0.0) t_c2 = $realtime;
    always @(posedge clken8)   if (t_ck < 0.0) t_ck = $realtime;
    always @(posedge slow8)    if (t_sr < 0.0) t_sr = $realtime;
    always @(negedge slow8)    if (t_sr >= 0.0 && t_sf < 0.0) t_sf = $realtime;

    a_width8: assert property (@(posedge sysclk) disable iff (reset) clken8 |=> !clken8)
        else $error("clken8 wider than one cycle");
    a_excl8: assert property (@(posedge sysclk) !(clken8 && clken2_8))
        else $error("clken8 and clken2_8 high together");
    a_rst8: assert property (@(posedge sysclk) reset |=> (!clken8 && !clken2_8 && !slow8))
        else $error("outputs nonzero after reset");

    typedef struct {
        logic rst;
        logic ck;
        logic c2;
        logic sl;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int n;
        logic slow_hold;

        // rst, clken, clken2, slowclk after each edge (DIVISOR=8)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1};

        for (int r = 0; r < 14; r++) begin
            reset = tbl[r].rst;
            @(posedge sysclk);
            #0.5;
            check($sformatf("tbl%0d_clken", r),   32'(clken8),   32'(tbl[r].ck));
            check($sformatf("tbl%0d_clken2", r),  32'(clken2_8), 32'(tbl[r].c2));
            check($sformatf("tbl%0d_slowclk", r), 32'(slow8),    32'(tbl[r].sl));
            @(negedge sysclk);
        end

        check("t_clken2_rise_ns",  32'(int'(t_c2)), 32'd11);
        check("t_slowclk_rise_ns", 32'(int'(t_sr)), 32'd11);
        check("t_clken_rise_ns",   32'(int'(t_ck)), 32'd19);
        check("t_slowclk_fall_ns", 32'(int'(t_sf)), 32'd19);

        repeat (40) @(negedge sysclk);
        check("period_d8_ns",  32'(int'(per_last[0])), 32'd16);
        check("period_d2_ns",  32'(int'(per_last[1])), 32'd4);
        check("period_d16_ns", 32'(int'(per_last[2])), 32'd32);

        // Mid-period reset: line up on a clken so the count is known, then reset at cnt=5.
        n = 0;
        for (int j = 1; j <= 40; j++) begin
            @(posedge sysclk); #0.5;
            if (clken8) begin n = j; break; end
        end
        check("sync_clken_found", 32'(n != 0), 32'd1);
        repeat (5) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        @(posedge sysclk); #0.5;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst_clken_d%0d", dv[i]),   32'(o_ck[i]), 32'd0);
            check($sformatf("midrst_clken2_d%0d", dv[i]),  32'(o_c2[i]), 32'd0);
            check($sformatf("midrst_slowclk_d%0d", dv[i]), 32'(o_sl[i]), 32'd0);
        end
        @(negedge sysclk);
        reset = 1'b0;
        n = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge sysclk); #0.5;
            if (clken2_8) begin n = j; break; end
        end
        check("midrst_clken2_edges", 32'(n), 32'd4);

`ifdef CLOCKEN_HALT_EN
        n = 0;
        for (int j = 1; j <= 40; j++) begin
            @(posedge sysclk); #0.5;
            if (clken8) begin n = j; break; end
        end
        check("halt_sync_found", 32'(n != 0), 32'd1);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        slow_hold = slow8;
        halt = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge sysclk); #0.5;
            check("halt_clken",   32'(clken8),   32'd0);
            check("halt_clken2",  32'(clken2_8), 32'd0);
            check("halt_slowclk", 32'(slow8),    32'(slow_hold));
        end
        @(negedge sysclk);
        halt = 1'b0;
        n = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge sysclk); #0.5;
            if (clken8) begin n = j; break; end
        end
        check("halt_resume_clken_edges", 32'(n), 32'd6);
`else
        slow_hold = 1'b0;
`endif

        repeat (40) @(negedge sysclk);
        check("final_period_d16_ns", 32'(int'(per_last[2])), 32'd32);
        check("sb_drained", 32'(sb_q.size() <= 1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
